alu_frame_sequencer: RTL and testbench
======================================

// Module: alu_frame_sequencer
// PURPOSE
//   Drives the Alu operand/opcode inputs from a byte stream, the hardware counterpart of a stimulus bench.
//   A frame is A bytes, then B bytes, then one opcode byte. Each frame executes once and the result R is
//   returned as a byte stream. Sits between a UART byte receiver/transmitter pair and the combinational Alu.
// PARAMETERS
//   bits            16   Alu operand/result width; must be a multiple of 8 (BYTES = bits/8)
//   op_bits         6    Alu opcode width; taken from the low op_bits of the opcode byte (op_bits <= 8)
//   timeout_cycles  1000 idle-gap limit inside a partial frame (only with ALUSEQ_TIMEOUT_EN)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   rx_data    in   8        received byte
//   rx_valid   in   1        one-cycle strobe, rx_data valid; no backpressure
//   tx_data    out  8        result byte, registered
//   tx_valid   out  1        tx_data valid; held until accepted
//   tx_ready   in   1        sink accepts byte when tx_valid && tx_ready at rising edge
//   alu_a      out  bits     Alu operand A, registered, held between frames
//   alu_b      out  bits     Alu operand B, registered, held between frames
//   alu_op     out  op_bits  Alu opcode, registered, held between frames
//   alu_r      in   bits     Alu result (combinational from alu_a/alu_b/alu_op)
//   busy       out  1        1 in EXEC or SEND
//   overrun    out  1        sticky: rx byte dropped
//   err_clr    in   1        synchronous clear of overrun
// BEHAVIOUR
//   Reset (rst_n=0, async): state=LD_A, byte count=0, all outputs and internal result reg = 0.
//   States: LD_A -> LD_B -> LD_OP -> EXEC -> SEND -> LD_A.
//   LD_A/LD_B: each rx_valid writes the byte into lane [8k+7:8k], LSB byte first, k = byte count.
//     Byte count increments per byte. After BYTES bytes: count=0, next state.
//     alu_a/alu_b update per byte, so partial values are visible.
//   LD_OP: rx_valid -> alu_op <= rx_data[op_bits-1:0], state -> EXEC.
//   EXEC: exactly one cycle. Result reg <= alu_r; tx_data <= alu_r[7:0]; tx_valid <= 1; state -> SEND.
//   Latency: opcode byte strobed in cycle N -> tx_valid=1 in cycle N+2.
//   SEND: on each handshake the next byte (LSB first) is loaded the following cycle, with no bubble.
//     tx_data is stable while tx_valid=1 && !tx_ready.
//     On the handshake of byte BYTES-1: tx_valid <= 0, state -> LD_A, count=0.
//   rx_valid in EXEC or SEND (including the final SEND handshake cycle): byte dropped, overrun <= 1.
//   err_clr and an overrun event in the same cycle: overrun stays 1 (set wins).
//   alu_a/alu_b/alu_op are never cleared between frames; only reset clears them.
//   Reset asserted mid-frame or mid-SEND: the frame is discarded, tx_valid drops immediately, and no partial byte is resent.
// CONFIGURATION
//   ALUSEQ_TIMEOUT_EN defined:
//     - A gap counter runs while in LD_A with count>0, in LD_B, or in LD_OP. It resets on every rx_valid.
//     - When it reaches timeout_cycles-1 with no rx_valid: state -> LD_A, count=0. Already-written alu_a/alu_b bytes are kept.
//     - No overrun is flagged for a timeout. No counter runs in LD_A with count=0, in EXEC, or in SEND.
//   ALUSEQ_TIMEOUT_EN undefined: no counter logic, and a partial frame waits indefinitely.
// TESTING (bits=16, op_bits=6)
//   Bench uses an Alu stub: op 6'h20 -> A+B, op 6'h24 -> A&B.
//   Basic: rx 34,12,0F,0F,20 with tx_ready=1 -> alu_a=1234, alu_b=0F0F, alu_op=20.
//     tx bytes 43 then 21 on consecutive cycles, starting 2 cycles after the opcode strobe; then busy=0.
//   Backpressure: same frame with op 24, tx_ready low 5 cycles -> tx_data=04 held 5 cycles.
//     Then 04, 02 transferred; no duplicate or lost byte.
//   Overrun: rx byte AA during SEND -> overrun=1, frame result unchanged.
//     Next frame decodes correctly. err_clr pulse -> overrun=0.
//   Reset mid-frame: rx 34,12,0F, then rst_n low 1 cycle -> alu_a=0, alu_b=0.
//     Next rx 01,00,02,00,20 -> tx 03,00.
//   Back-to-back: two frames with 1-cycle rx gaps and tx_ready=1 -> both results correct, overrun=0.
//   Timeout (ALUSEQ_TIMEOUT_EN, timeout_cycles=20): rx 34, wait 25 cycles -> state LD_A, count=0.
//     rx 05,00,01,00,20 -> tx 06,00. Without the macro the same stimulus instead yields alu_a=0534.

Source files
------------

// File: rtl/alu_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_frame_sequencer: loads Alu A/B/opcode from a byte stream, executes once |
// | and streams the result back LSB first. Option macro: ALUSEQ_TIMEOUT_EN.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_frame_sequencer #(
  parameter int BITS           = 16,
  parameter int OP_BITS        = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [BITS-1:0]    alu_a,
  output logic [BITS-1:0]    alu_b,
  output logic [OP_BITS-1:0] alu_op,
  input  logic [BITS-1:0]    alu_r,
  output logic               busy,
  output logic               overrun,
  input  logic               err_clr
);

  localparam int BYTES = BITS / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_LD_A  = 3'd0,
    ST_LD_B  = 3'd1,
    ST_LD_OP = 3'd2,
    ST_EXEC  = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [BITS-1:0]     alu_a_q;
  logic [BITS-1:0]     alu_b_q;
  logic [OP_BITS-1:0]  alu_op_q;
  logic [BITS-1:0]     res_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                overrun_q;
  logic                drop_d;
  logic                gap_expired_d;

  assign cnt_d  = cnt_q + 1'b1;
  assign drop_d = rx_valid && ((state_q == ST_EXEC) || (state_q == ST_SEND));

`ifdef ALUSEQ_TIMEOUT_EN
  localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [GW-1:0] gap_q;
  logic          gap_active_d;

  // Only a partially received frame is timed; an idle LD_A never times out.
  assign gap_active_d  = ((state_q == ST_LD_A) && (cnt_q != '0)) ||
                         (state_q == ST_LD_B) || (state_q == ST_LD_OP);
  assign gap_expired_d = gap_active_d && !rx_valid &&
                         (gap_q == GW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (!gap_active_d || rx_valid || gap_expired_d) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 1'b1;
    end
  end
`else
  assign gap_expired_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LD_A;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // A drop in the same cycle as err_clr leaves the flag set.
      if (err_clr) overrun_q <= 1'b0;
      if (drop_d)  overrun_q <= 1'b1;

      case (state_q)
        ST_LD_A: begin
          if (rx_valid) begin
            alu_a_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            if (cnt_q == C_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_LD_B;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        ST_LD_B: begin
          if (rx_valid) begin
            alu_b_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            if (cnt_q == C_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_LD_OP;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        ST_LD_OP: begin
          if (rx_valid) begin
            alu_op_q <= rx_data[OP_BITS-1:0];
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q      <= alu_r;
          tx_data_q  <= alu_r[7:0];
          tx_valid_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (cnt_q == C_LAST) begin
              tx_valid_q <= 1'b0;
              cnt_q      <= '0;
              state_q    <= ST_LD_A;
            end else begin
              tx_data_q <= res_q[{cnt_d, 3'b000} +: 8];
              cnt_q     <= cnt_d;
            end
          end
        end
        default: begin
          state_q <= ST_LD_A;
          cnt_q   <= '0;
        end
      endcase

      if (gap_expired_d) begin
        state_q <= ST_LD_A;
        cnt_q   <= '0;
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q == ST_EXEC) || (state_q == ST_SEND);

endmodule
`default_nettype wire

// File: tb/tb_alu_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_frame_sequencer: bench for alu_frame_sequencer with an Alu stub.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_alu_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_op;
  logic [15:0] alu_r;
  logic        busy;
  logic        overrun;
  logic        err_clr = 1'b0;

  int          tests = 0;
  int          fails = 0;
  bit          rnd_ready = 1'b0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  alu_frame_sequencer #(
    .BITS(16), .OP_BITS(6), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .busy(busy), .overrun(overrun), .err_clr(err_clr)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h24:   return a & b;
      6'h22:   return a - b;
      6'h26:   return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_r = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Every cycle: score any tx handshake at the negedge, then advance to posedge+1.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (rst_n && tx_valid && tx_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL tx_byte: got %h expected %h", tx_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] op, input int gap);
    logic [7:0] seq [5];
    seq[0] = a[7:0]; seq[1] = a[15:8]; seq[2] = b[7:0]; seq[3] = b[15:8]; seq[4] = op;
    for (int k = 0; k < 5; k++) begin
      rx_byte(seq[k]);
      if (k < 4) repeat (gap) tick();
    end
  endtask

  task automatic push_result(input logic [15:0] r);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || tx_valid) && n < 100) begin
      tick();
      n++;
    end
    if (busy || tx_valid) check({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  opb;
    logic [5:0]  exp_op;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{16'h1234, 16'h0F0F, 8'h20, 6'h20, 16'h2143};
    vecs[1] = '{16'h1234, 16'h0F0F, 8'h24, 6'h24, 16'h0204};
    vecs[2] = '{16'hFFFF, 16'h0001, 8'h20, 6'h20, 16'h0000};
    vecs[3] = '{16'h00FF, 16'h0001, 8'h20, 6'h20, 16'h0100};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 8'h24, 6'h24, 16'hFFFF};
    vecs[5] = '{16'h5A5A, 16'hA5A5, 8'h26, 6'h26, 16'hFFFF};
    vecs[6] = '{16'h0005, 16'h0007, 8'h22, 6'h22, 16'hFFFE};
    vecs[7] = '{16'h1234, 16'h5678, 8'hFF, 6'h3F, 16'h0000};
    vecs[8] = '{16'h0001, 16'h0002, 8'hE0, 6'h20, 16'h0003};

    // Reset state
    tick(); tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    // Table of frames with exact latency and back-to-back byte timing
    foreach (vecs[i]) begin
      send_frame(vecs[i].a, vecs[i].b, vecs[i].opb, i % 3);
      push_result(vecs[i].exp_r);
      check("vec_alu_a", alu_a, vecs[i].a);
      check("vec_alu_b", alu_b, vecs[i].b);
      check("vec_alu_op", alu_op, vecs[i].exp_op);
      check("vec_latency_n1", tx_valid, 0);
      check("vec_busy_exec", busy, 1);
      tick();
      check("vec_latency_n2", tx_valid, 1);
      check("vec_byte0", tx_data, vecs[i].exp_r[7:0]);
      tick();
      check("vec_byte1_valid", tx_valid, 1);
      check("vec_byte1", tx_data, vecs[i].exp_r[15:8]);
      tick();
      check("vec_done_valid", tx_valid, 0);
      check("vec_done_busy", busy, 0);
    end
    check("vec_queue_empty", exp_q.size(), 0);

    // Backpressure holds the first byte
    tx_ready = 1'b0;
    send_frame(16'h1234, 16'h0F0F, 8'h24, 0);
    push_result(16'h0204);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", tx_valid, 1);
      check("bp_hold_data", tx_data, 8'h04);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    check("bp_second", tx_data, 8'h02);
    tick();
    check("bp_done", tx_valid, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Overrun during EXEC/SEND, set-wins, then clear
    tx_ready = 1'b0;
    send_frame(16'h1234, 16'h0F0F, 8'h20, 0);
    push_result(16'h2143);
    rx_byte(8'hAA);
    check("ovr_set", overrun, 1);
    check("ovr_tx_data", tx_data, 8'h43);
    err_clr  = 1'b1;
    rx_byte(8'hAA);
    err_clr  = 1'b0;
    check("ovr_set_wins", overrun, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    tx_ready = 1'b1;
    wait_idle("ovr");
    check("ovr_alu_a_kept", alu_a, 16'h1234);
    check("ovr_queue_empty", exp_q.size(), 0);
    send_frame(16'h0001, 16'h0002, 8'h20, 1);
    push_result(16'h0003);
    wait_idle("ovr_next");
    check("ovr_next_queue", exp_q.size(), 0);

    // Reset mid-frame
    rx_byte(8'h34); rx_byte(8'h12); rx_byte(8'h0F);
    rst_n = 1'b0;
    tick();
    check("rmf_alu_a", alu_a, 0);
    check("rmf_alu_b", alu_b, 0);
    rst_n = 1'b1;
    tick();
    send_frame(16'h0001, 16'h0002, 8'h20, 0);
    push_result(16'h0003);
    wait_idle("rmf");
    check("rmf_queue_empty", exp_q.size(), 0);

    // Reset mid-send: tx_valid drops without waiting for a clock
    tx_ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 8'h20, 0);
    tick();
    check("rms_valid_before", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rms_async_drop", tx_valid, 0);
    tick();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (4) tick();
    check("rms_no_resend", tx_valid, 0);

    // Back-to-back frames with 1-cycle rx gaps
    send_frame(16'hA0A0, 16'h0505, 8'h20, 1);
    push_result(16'hA5A5);
    wait_idle("b2b_1");
    send_frame(16'hF00F, 16'h0FF0, 8'h24, 1);
    push_result(16'h0000);
    wait_idle("b2b_2");
    check("b2b_overrun", overrun, 0);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Idle gap inside a partial frame
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rx_byte(8'h34);
    repeat (25) tick();
`ifdef ALUSEQ_TIMEOUT_EN
    check("to_alu_a_kept", alu_a, 16'h0034);
    check("to_idle_busy", busy, 0);
    send_frame(16'h0005, 16'h0001, 8'h20, 0);
    push_result(16'h0006);
    check("to_alu_a", alu_a, 16'h0005);
    wait_idle("to");
    check("to_overrun", overrun, 0);
    check("to_queue_empty", exp_q.size(), 0);
`else
    rx_byte(8'h05);
    check("noto_alu_a", alu_a, 16'h0534);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized frames against the scoreboard, random tx_ready
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [15:0] ra, rb;
      logic [7:0]  rop;
      int          sel;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      sel = $urandom_range(0, 4);
      rop = (sel == 0) ? 8'h20 : (sel == 1) ? 8'h24 : (sel == 2) ? 8'h22 :
            (sel == 3) ? 8'h26 : 8'($urandom);
      send_frame(ra, rb, rop, $urandom_range(0, 2));
      push_result(alu_f(ra, rb, rop[5:0]));
      check("rnd_alu_a", alu_a, ra);
      check("rnd_alu_b", alu_b, rb);
      check("rnd_alu_op", alu_op, rop[5:0]);
      wait_idle("rnd");
    end
    rnd_ready = 1'b0;
    tx_ready  = 1'b1;
    tick();
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
